// File: rtl/uart_rx_ctrl.sv
// UART receiver controller: oversampled start detection with false-start
// rejection, LSB-first data capture, stop-bit framing check, break hold-off,
// and a single-entry output register with valid/overrun handshake.
module uart_rx_ctrl #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATABITS   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                rxd,
    input  logic                rd,
    output logic [DATABITS-1:0] data,
    output logic                valid,
    output logic                frame_err,
    output logic                overrun,
    output logic                busy
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATABITS + 1);

    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATABITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [BW-1:0]       bitcnt;
    logic [DATABITS-1:0] shift;
    logic                rx_meta;
    logic                rxs;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    // Frame FSM plus output register; counters and state move only on tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bitcnt    <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // Consumer acknowledge; a completing byte below overrides valid.
            if (rd && valid) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end
            if (tick) begin
                case (state)
                    IDLE: begin
                        if (!rxs) begin
                            state <= START;
                            cnt   <= '0;
                        end
                    end
                    START: begin
                        if (cnt == CNT_HALF) begin
                            if (!rxs) begin
                                state  <= DATA;
                                cnt    <= '0;
                                bitcnt <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    DATA: begin
                        if (cnt == CNT_LAST) begin
                            shift  <= {rxs, shift[DATABITS-1:1]};
                            cnt    <= '0;
                            bitcnt <= bitcnt + BW'(1);
                            if (bitcnt == BIT_LAST) begin
                                state <= STOP;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    STOP: begin
                        if (cnt == CNT_LAST) begin
                            data      <= shift;
                            frame_err <= ~rxs;
                            valid     <= 1'b1;
                            // Unread byte overwritten -> overrun, unless it is
                            // being acknowledged on this very cycle.
                            if (valid) begin
                                overrun <= ~rd;
                            end
                            cnt   <= '0;
                            state <= rxs ? IDLE : BREAK;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    BREAK: begin
                        if (rxs) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Busy whenever a frame (or break) is in progress.
    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed frame scenarios followed by
// randomized frames, glitches and acknowledges, checked against a
// byte-level reference model of the receiver's output register.
module tb_uart_rx_ctrl;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick  = 1'b0;
    logic       rxd   = 1'b1;
    logic       rd    = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned ph     = 0;

    // Byte-level reference model of the output register.
    logic [7:0] m_data  = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ferr  = 1'b0;
    logic       m_ov    = 1'b0;

    // Bit period in clk cycles (16 ticks x 4 clk); stop sample lands
    // 612 clk after the start edge is applied on a tick-aligned cycle.
    localparam int unsigned BITCLK   = 64;
    localparam int unsigned DONE_CLK = 612;

    uart_rx_ctrl #(
        .OVERSAMPLE(16),
        .DATABITS  (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .rxd      (rxd),
        .rd       (rd),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Baud generator: one-cycle tick every 4 clk.
    always @(negedge clk) begin
        tick = ((ph % 4) == 3);
        ph   = ph + 1;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        errors = errors + 1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Stop just before a tick cycle so frames start at a known tick phase.
    task automatic align();
        do step(); while (tick !== 1'b1);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stopb, input int unsigned low_bits);
        rxd = 1'b0;
        repeat (BITCLK) step();
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BITCLK) step();
        end
        rxd = stopb;
        repeat (BITCLK * (stopb ? 1 : low_bits)) step();
        rxd = 1'b1;
    endtask

    task automatic model_complete(input logic [7:0] b, input logic stopb, input logic rd_now);
        if (m_valid) m_ov = !rd_now;
        m_data  = b;
        m_ferr  = !stopb;
        m_valid = 1'b1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data"},  {24'h0, data}, {24'h0, m_data});
        check({tag, ".valid"}, {31'h0, valid}, {31'h0, m_valid});
        check({tag, ".ferr"},  {31'h0, frame_err}, {31'h0, m_ferr});
        check({tag, ".ovr"},   {31'h0, overrun}, {31'h0, m_ov});
        check({tag, ".busy"},  {31'h0, busy}, 32'h0);
    endtask

    task automatic send(input logic [7:0] b, input logic stopb, input int unsigned low_bits, input string tag);
        align();
        drive_frame(b, stopb, low_bits);
        model_complete(b, stopb, 1'b0);
        repeat (12) step();
        check_all(tag);
    endtask

    // Frame with rd asserted on exactly the stop-sample cycle.
    task automatic send_rd(input logic [7:0] b, input logic stopb, input int unsigned low_bits, input string tag);
        align();
        fork
            drive_frame(b, stopb, low_bits);
            begin
                repeat (DONE_CLK) step();
                rd = 1'b1;
                step();
                rd = 1'b0;
            end
        join
        model_complete(b, stopb, 1'b1);
        repeat (12) step();
        check_all(tag);
    endtask

    task automatic rd_pulse(input string tag);
        step();
        rd = 1'b1;
        step();
        rd = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ov    = 1'b0;
        end
        check_all(tag);
    endtask

    task automatic glitch(input int unsigned len, input string tag);
        align();
        rxd = 1'b0;
        repeat (len) step();
        rxd = 1'b1;
        repeat (48) step();
        check_all(tag);
    endtask

    initial begin
        logic [7:0]  b;
        logic        sb;
        int unsigned lb;
        int unsigned r;

        // Reset state
        repeat (2) step();
        check_all("reset");
        repeat (2) step();
        rst_n = 1'b1;
        repeat (8) step();

        // 0xA5 with exact stop-sample timing
        align();
        fork
            drive_frame(8'hA5, 1'b1, 1);
            begin
                repeat (DONE_CLK) step();
                check("a5.pre_valid", {31'h0, valid}, 32'h0);
                check("a5.pre_busy", {31'h0, busy}, 32'h1);
                step();
                check("a5.post_valid", {31'h0, valid}, 32'h1);
                check("a5.post_data", {24'h0, data}, 32'hA5);
                check("a5.post_busy", {31'h0, busy}, 32'h0);
            end
        join
        model_complete(8'hA5, 1'b1, 1'b0);
        repeat (12) step();
        check_all("a5");

        // Short start glitch is rejected
        rd_pulse("rd0");
        glitch(20, "glitch");

        // Break: stop low, line low three bit times
        align();
        fork
            drive_frame(8'h3C, 1'b0, 3);
            begin
                repeat (DONE_CLK + 20) step();
                check("brk.busy", {31'h0, busy}, 32'h1);
                check("brk.valid", {31'h0, valid}, 32'h1);
                check("brk.ferr", {31'h0, frame_err}, 32'h1);
                check("brk.data", {24'h0, data}, 32'h3C);
            end
        join
        model_complete(8'h3C, 1'b0, 1'b0);
        repeat (12) step();
        check_all("brk");
        rd_pulse("rd1");
        send(8'h55, 1'b1, 1, "b55");

        // Overrun on back-to-back unread bytes, cleared by one rd
        rd_pulse("rd2");
        send(8'h11, 1'b1, 1, "ov11");
        send(8'h22, 1'b1, 1, "ov22");
        rd_pulse("ovclr");

        // rd coincident with completion
        send(8'h33, 1'b1, 1, "c33");
        send(8'h11, 1'b1, 1, "c11");
        send_rd(8'h22, 1'b1, 1, "c22");

        // Reset mid-frame during data bit 4 of 0xF0
        align();
        fork
            drive_frame(8'hF0, 1'b1, 1);
            begin
                repeat (BITCLK * 5 + 32) step();
                rst_n = 1'b0;
                #1;
                check("rst.data", {24'h0, data}, 32'h0);
                check("rst.valid", {31'h0, valid}, 32'h0);
                check("rst.ferr", {31'h0, frame_err}, 32'h0);
                check("rst.ovr", {31'h0, overrun}, 32'h0);
                check("rst.busy", {31'h0, busy}, 32'h0);
                repeat (3) step();
                rst_n = 1'b1;
            end
        join
        m_data  = 8'h00;
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        m_ov    = 1'b0;
        repeat (12) step();
        check_all("rst_after");
        send(8'h81, 1'b1, 1, "b81");

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                glitch($urandom_range(1, 24), "rglitch");
            end else begin
                b  = 8'($urandom);
                sb = ($urandom_range(0, 4) != 0);
                lb = $urandom_range(1, 3);
                if (r < 3) send_rd(b, sb, lb, "rframe_rd");
                else       send(b, sb, lb, "rframe");
            end
            if ($urandom_range(0, 9) < 4) rd_pulse("rrd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
